// File: rtl/drum_motor_controller_if.sv
// Run request, target rpm and mode from the wash FSM; registered drive commands and status back.
interface drum_motor_controller_if;
  logic        enable;
  logic [10:0] target_speed;
  logic        agitate;
  logic        estop;
  logic [10:0] motor_speed;
  logic        motor_dir;
  logic        motor_on;
  logic        at_speed;
  logic        stopped;

  modport master (
    output enable, target_speed, agitate, estop,
    input  motor_speed, motor_dir, motor_on, at_speed, stopped
  );

  modport slave (
    input  enable, target_speed, agitate, estop,
    output motor_speed, motor_dir, motor_on, at_speed, stopped
  );
endinterface

// File: rtl/drum_motor_controller.sv
// Washer drum motor speed ramp / agitation reversal controller.
// Speed moves one RAMP_STEP per tick (TICK_DIV clk); estop drops speed to 0 at the next edge.
module drum_motor_controller #(
  parameter logic [15:0] TICK_DIV         = 16'd4,
  parameter logic [10:0] RAMP_STEP        = 11'd20,
  parameter logic [10:0] MAX_SPEED        = 11'd1600,
  parameter logic [7:0]  AGIT_ON_TICKS    = 8'd3,
  parameter logic [7:0]  AGIT_PAUSE_TICKS = 8'd2
) (
  input  logic                     clk,
  input  logic                     reset,
  drum_motor_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_STOPPED   = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_REV_PAUSE = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_presc, w_presc_nxt;
  logic [10:0] r_speed, w_speed_nxt;
  logic        r_dir, w_dir_nxt;
  logic        r_rev, w_rev_nxt;
  logic [7:0]  r_stroke, w_stroke_nxt;
  logic [7:0]  r_pause, w_pause_nxt;

  logic [10:0] w_eff;
  logic        w_tick;
  logic [11:0] w_sum;
  logic [10:0] w_up;
  logic [10:0] w_dn;
  logic [10:0] w_trk;
  logic [10:0] w_up_now;
  logic [10:0] w_dn_now;
  logic        w_stroke_done;
  logic        w_pause_done;

  assign w_eff  = (bus.target_speed > MAX_SPEED) ? MAX_SPEED : bus.target_speed;
  assign w_tick = (r_state != ST_STOPPED) && (r_presc == TICK_DIV - 16'd1);

  // 12-bit sum so speed + step never wraps before the clamp.
  assign w_sum    = {1'b0, r_speed} + {1'b0, RAMP_STEP};
  assign w_up     = (w_sum > {1'b0, w_eff}) ? w_eff : w_sum[10:0];
  assign w_dn     = (r_speed > RAMP_STEP) ? (r_speed - RAMP_STEP) : 11'd0;
  assign w_trk    = (r_speed < w_eff) ? w_up :
                    ((r_speed - w_eff) > RAMP_STEP) ? w_dn : w_eff;
  assign w_up_now = w_tick ? w_up : r_speed;
  assign w_dn_now = w_tick ? w_dn : r_speed;

  assign w_stroke_done = ({1'b0, r_stroke} + 9'd1) >= {1'b0, AGIT_ON_TICKS};
  assign w_pause_done  = ({1'b0, r_pause} + 9'd1) >= {1'b0, AGIT_PAUSE_TICKS};

  always_comb begin
    w_state_nxt  = r_state;
    w_speed_nxt  = r_speed;
    w_dir_nxt    = r_dir;
    w_rev_nxt    = r_rev;
    w_stroke_nxt = 8'd0;
    w_pause_nxt  = 8'd0;
    w_presc_nxt  = 16'd0;

    if (bus.estop) begin
      w_state_nxt = ST_STOPPED;
      w_speed_nxt = 11'd0;
      w_rev_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_STOPPED: begin
          w_speed_nxt = 11'd0;
          if (bus.enable && (w_eff != 11'd0))
            w_state_nxt = ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          w_speed_nxt = w_up_now;
          if (!bus.enable) begin
            w_state_nxt = ST_RAMP_DOWN;
            w_rev_nxt   = 1'b0;
          end else if (w_up_now == w_eff) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_tick)
            w_speed_nxt = w_trk;
          w_stroke_nxt = bus.agitate ? r_stroke : 8'd0;
          if (!bus.enable) begin
            w_state_nxt = ST_RAMP_DOWN;
            w_rev_nxt   = 1'b0;
          end else if (bus.agitate && w_tick) begin
            if (w_stroke_done) begin
              w_state_nxt = ST_RAMP_DOWN;
              w_rev_nxt   = 1'b1;
            end else begin
              w_stroke_nxt = r_stroke + 8'd1;
            end
          end
        end
        ST_RAMP_DOWN: begin
          w_speed_nxt = w_dn_now;
          // A reversal stroke must reach standstill before the direction flips.
          if (bus.enable && !r_rev)
            w_state_nxt = ST_RAMP_UP;
          else if (w_dn_now == 11'd0)
            w_state_nxt = r_rev ? ST_REV_PAUSE : ST_STOPPED;
        end
        ST_REV_PAUSE: begin
          w_speed_nxt = 11'd0;
          w_pause_nxt = r_pause;
          if (!bus.enable) begin
            w_state_nxt = ST_STOPPED;
            w_rev_nxt   = 1'b0;
          end else if (w_tick) begin
            if (w_pause_done) begin
              w_state_nxt = ST_RAMP_UP;
              w_dir_nxt   = ~r_dir;
              w_rev_nxt   = 1'b0;
            end else begin
              w_pause_nxt = r_pause + 8'd1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_STOPPED;
          w_speed_nxt = 11'd0;
        end
      endcase
    end

    if (w_state_nxt != r_state) begin
      w_stroke_nxt = 8'd0;
      w_pause_nxt  = 8'd0;
    end

    if ((w_state_nxt != r_state) || (r_state == ST_STOPPED) || w_tick)
      w_presc_nxt = 16'd0;
    else
      w_presc_nxt = r_presc + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_STOPPED;
      r_presc  <= 16'd0;
      r_speed  <= 11'd0;
      r_dir    <= 1'b0;
      r_rev    <= 1'b0;
      r_stroke <= 8'd0;
      r_pause  <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_speed  <= w_speed_nxt;
      r_dir    <= w_dir_nxt;
      r_rev    <= w_rev_nxt;
      r_stroke <= w_stroke_nxt;
      r_pause  <= w_pause_nxt;
    end
  end

  assign bus.motor_speed = r_speed;
  assign bus.motor_dir   = r_dir;
  assign bus.motor_on    = (r_state == ST_RAMP_UP) || (r_state == ST_RUN) ||
                           (r_state == ST_RAMP_DOWN);
  assign bus.at_speed    = (r_state == ST_RUN) && (r_speed == w_eff);
  assign bus.stopped     = (r_state == ST_STOPPED);

endmodule

// File: tb/tb_drum_motor_controller.sv
// Directed bench for drum_motor_controller: ramp, estop, agitation, stop/restart, clamp, async reset.
module tb_drum_motor_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  drum_motor_controller_if bus ();

  drum_motor_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset            = 1'b0;
    bus.enable       = 1'b0;
    bus.target_speed = 11'd0;
    bus.agitate      = 1'b0;
    bus.estop        = 1'b0;

    #3;
    chk("rst_speed",   bus.motor_speed, 0);
    chk("rst_dir",     bus.motor_dir,   0);
    chk("rst_on",      bus.motor_on,    0);
    chk("rst_atspeed", bus.at_speed,    0);
    chk("rst_stopped", bus.stopped,     1);
    step(2);
    reset = 1'b1;

    // Ramp 0 -> 100, one step every 4 clk
    bus.enable       = 1'b1;
    bus.target_speed = 11'd100;
    step(1);
    chk("ramp_on", bus.motor_on, 1);
    chk("ramp_start", bus.motor_speed, 0);
    for (int k = 1; k <= 5; k++) begin
      step(4);
      chk("ramp_speed", bus.motor_speed, 20 * k);
      chk("ramp_atspeed", bus.at_speed, (k == 5) ? 1 : 0);
    end

    // Emergency stop at 100
    bus.estop = 1'b1;
    step(1);
    chk("estop_speed",   bus.motor_speed, 0);
    chk("estop_stopped", bus.stopped,     1);
    chk("estop_on",      bus.motor_on,    0);
    bus.estop  = 1'b0;
    bus.enable = 1'b0;
    step(2);
    chk("estop_hold", bus.stopped, 1);

    // Agitation stroke at 40 rpm
    bus.target_speed = 11'd40;
    bus.agitate      = 1'b1;
    bus.enable       = 1'b1;
    step(1);
    chk("agit_on", bus.motor_on, 1);
    step(8);
    chk("agit_up_speed", bus.motor_speed, 40);
    chk("agit_up_at",    bus.at_speed,    1);
    step(8);
    chk("agit_run_at",   bus.at_speed,    1);
    step(4);
    chk("agit_dn_at",    bus.at_speed,    0);
    chk("agit_dn_on",    bus.motor_on,    1);
    chk("agit_dn_speed", bus.motor_speed, 40);
    step(4);
    chk("agit_dn20", bus.motor_speed, 20);
    step(4);
    chk("agit_dn0",       bus.motor_speed, 0);
    chk("agit_pause_on",  bus.motor_on,    0);
    chk("agit_pause_stp", bus.stopped,     0);
    chk("agit_pause_dir", bus.motor_dir,   0);
    step(4);
    chk("agit_pause_dir2", bus.motor_dir, 0);
    step(4);
    chk("agit_rev_dir", bus.motor_dir, 1);
    chk("agit_rev_on",  bus.motor_on,  1);
    step(8);
    chk("agit_back_speed", bus.motor_speed, 40);
    chk("agit_back_at",    bus.at_speed,    1);
    bus.agitate = 1'b0;

    // Stop from 60 with direction held
    bus.target_speed = 11'd60;
    step(4);
    chk("stop_pre60", bus.motor_speed, 60);
    bus.enable = 1'b0;
    step(1);
    chk("stop_dn_on", bus.motor_on, 1);
    step(4);
    chk("stop_40", bus.motor_speed, 40);
    step(4);
    chk("stop_20", bus.motor_speed, 20);
    step(4);
    chk("stop_0",       bus.motor_speed, 0);
    chk("stop_stopped", bus.stopped,     1);
    chk("stop_dir",     bus.motor_dir,   1);

    // Re-enable during RAMP_DOWN at 20 resumes ramp-up from 20
    bus.enable = 1'b1;
    step(13);
    chk("reup_60", bus.motor_speed, 60);
    bus.enable = 1'b0;
    step(9);
    chk("reup_dn20", bus.motor_speed, 20);
    bus.enable = 1'b1;
    step(1);
    chk("reup_hold20",  bus.motor_speed, 20);
    chk("reup_on",      bus.motor_on,    1);
    chk("reup_stopped", bus.stopped,     0);
    step(4);
    chk("reup_40", bus.motor_speed, 40);
    step(4);
    chk("reup_60b", bus.motor_speed, 60);
    chk("reup_at",  bus.at_speed,    1);

    // Clamp at MAX_SPEED, then small decrease to 1590
    bus.target_speed = 11'd1800;
    step(304);
    chk("clamp_1580", bus.motor_speed, 1580);
    step(4);
    chk("clamp_1600", bus.motor_speed, 1600);
    chk("clamp_at",   bus.at_speed,    1);
    step(4);
    chk("clamp_hold", bus.motor_speed, 1600);
    bus.target_speed = 11'd1590;
    step(4);
    chk("clamp_1590",    bus.motor_speed, 1590);
    chk("clamp_1590_at", bus.at_speed,    1);

    // Async reset mid RAMP_UP
    bus.estop = 1'b1;
    step(1);
    chk("estop2_speed", bus.motor_speed, 0);
    chk("estop2_dir",   bus.motor_dir,   1);
    bus.estop = 1'b0;
    step(9);
    chk("rup_40", bus.motor_speed, 40);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_speed",   bus.motor_speed, 0);
    chk("arst_dir",     bus.motor_dir,   0);
    chk("arst_on",      bus.motor_on,    0);
    chk("arst_atspeed", bus.at_speed,    0);
    chk("arst_stopped", bus.stopped,     1);
    step(1);
    reset = 1'b1;
    step(1);
    chk("rel_first_edge", bus.motor_on, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drum_motor_controller.md
DRUM_MOTOR_CONTROLLER -- requirements
Module: drum_motor_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named as the codebase names them: clk and reset.
REQ-002 The block SHALL have parameter TICK_DIV, default 16'd4, giving the number of clk cycles per ramp tick.
REQ-003 The block SHALL have parameter RAMP_STEP, default 11'd20, giving the speed change in rpm per tick.
REQ-004 The block SHALL have parameter MAX_SPEED, default 11'd1600, giving the speed clamp in rpm.
REQ-005 The block SHALL have parameter AGIT_ON_TICKS, default 8'd3, giving the number of RUN ticks per agitation stroke.
REQ-006 The block SHALL have parameter AGIT_PAUSE_TICKS, default 8'd2, giving the number of standstill ticks before a direction reversal.
REQ-007 The block SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous reset, active low.
REQ-009 The block SHALL have port enable, input, 1 bit: motor run request from the wash FSM.
REQ-010 The block SHALL have port target_speed, input, 11 bits: requested rpm.
REQ-011 The block SHALL have port agitate, input, 1 bit: 1 = wash/rinse reversing mode, 0 = continuous spin.
REQ-012 The block SHALL have port estop, input, 1 bit: emergency stop (vibration, cancel).
REQ-013 The block SHALL have port motor_speed, output, 11 bits: registered commanded rpm.
REQ-014 The block SHALL have port motor_dir, output, 1 bit: registered rotation direction, 0 = CW.
REQ-015 The block SHALL have port motor_on, output, 1 bit: 1 in RAMP_UP, RUN and RAMP_DOWN.
REQ-016 The block SHALL have port at_speed, output, 1 bit: 1 when state is RUN and motor_speed equals eff_target.
REQ-017 The block SHALL have port stopped, output, 1 bit: 1 when state is STOPPED.

Function
REQ-018 eff_target SHALL equal min(target_speed, MAX_SPEED) and SHALL be evaluated combinationally every cycle.
REQ-019 The prescaler SHALL be held at 0 in STOPPED and SHALL be cleared on every state change.
- Otherwise it counts 0..TICK_DIV-1 and wraps.
- tick = 1 on the cycle the prescaler equals TICK_DIV-1.
REQ-020 The state machine SHALL have states STOPPED, RAMP_UP, RUN, RAMP_DOWN and REV_PAUSE, and SHALL register all transitions on the clk edge.
REQ-021 estop=1 SHALL take highest priority: at the next edge, state becomes STOPPED and motor_speed becomes 0, motor_dir is unchanged, and the reversal flag is cleared.
REQ-022 STOPPED SHALL go to RAMP_UP when enable=1 and eff_target != 0, and SHALL otherwise hold with motor_speed=0.
REQ-023 RAMP_UP SHALL set motor_speed = min(motor_speed + RAMP_STEP, eff_target) on each tick, using 12-bit intermediate arithmetic with no wrap.
- Goes to RUN on the edge where motor_speed reaches eff_target.
REQ-024 RUN SHALL track eff_target on each tick, moving by at most RAMP_STEP toward it in either direction without overshoot.
REQ-025 In RUN with agitate=1, a stroke counter SHALL count ticks; after AGIT_ON_TICKS ticks, the state goes to RAMP_DOWN with the reversal flag set.
- The counter clears on RUN entry.
- With agitate=0, the counter is held at 0.
REQ-026 enable=0 in RAMP_UP or RUN SHALL cause a transition to RAMP_DOWN with the reversal flag cleared.
REQ-027 RAMP_DOWN SHALL set motor_speed = max(motor_speed - RAMP_STEP, 0) on each tick, saturating at 0.
- At motor_speed = 0: goes to REV_PAUSE if the reversal flag is set, otherwise to STOPPED.
REQ-028 enable returning to 1 during a RAMP_DOWN with the reversal flag clear SHALL cause a transition to RAMP_UP from the current speed; a reversal RAMP_DOWN SHALL always complete.
REQ-029 REV_PAUSE SHALL hold motor_speed=0 and count AGIT_PAUSE_TICKS ticks.
- Then toggles motor_dir, clears the reversal flag and goes to RAMP_UP.
- enable=0 in REV_PAUSE goes to STOPPED at the next edge without toggling motor_dir.
REQ-030 motor_dir SHALL change only on REV_PAUSE exit to RAMP_UP.
REQ-031 When tick coincides with a transition, the transition SHALL take precedence and the speed update SHALL be applied per the current state.

Reset
REQ-032 reset=0 SHALL asynchronously force the following, independent of clk:
- state STOPPED, motor_speed 0, motor_dir 0, motor_on 0, at_speed 0, stopped 1;
- prescaler 0, stroke and pause counters 0, reversal flag 0.
REQ-033 Reset deassertion SHALL be sampled synchronously; the first transition SHALL be possible at the first clk edge after reset=1.

Verification
REQ-034 Ramp: enable=1, target 100, agitate=0 -> motor_speed 20,40,60,80,100, one step per 4 clk, RUN with at_speed=1 after 20 clk.
REQ-035 Clamp: target 1800 -> motor_speed saturates at 1600 and at_speed=1; target then lowered to 1590 -> motor_speed reaches 1590 on the next tick.
REQ-036 Agitation: target 40, agitate=1 -> 3 RUN ticks, down to 0, 2 pause ticks, motor_dir toggles to 1, ramp back to 40.
REQ-037 Stop: enable=0 in RUN at 60 -> 40,20,0, then STOPPED with motor_dir unchanged; enable=1 at speed 20 -> RAMP_UP from 20.
REQ-038 Emergency stop: estop pulse at speed 100 -> motor_speed=0 and stopped=1 on the next edge; reset=0 mid-RAMP_UP -> all outputs at reset values immediately.
